// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg : shared types and constants for the MIPS pipeline stages
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam int WORD_W  = 32;
  localparam int MD_ITER = 32;

  // Control-bit positions shared with the MEM stage
  localparam int M_READ_BIT        = 1;
  localparam int M_WRITE_BIT       = 0;
  localparam int WB_REG_WRITE_BIT  = 1;
  localparam int WB_MEM_TO_REG_BIT = 0;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_NOR   = 5'd5,
    OP_SLT   = 5'd6,
    OP_SLTU  = 5'd7,
    OP_LUI   = 5'd8,
    OP_SLL   = 5'd9,
    OP_SRL   = 5'd10,
    OP_SRA   = 5'd11,
    OP_SLLV  = 5'd12,
    OP_SRLV  = 5'd13,
    OP_SRAV  = 5'd14,
    OP_MFHI  = 5'd15,
    OP_MFLO  = 5'd16,
    OP_MTHI  = 5'd17,
    OP_MTLO  = 5'd18,
    OP_MULT  = 5'd19,
    OP_MULTU = 5'd20,
    OP_DIV   = 5'd21,
    OP_DIVU  = 5'd22
  } alu_op_t;

  function automatic logic is_md_op(input alu_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Every op that touches HI/LO must wait for the iterative unit
  function automatic logic is_hilo_op(input alu_op_t op);
    return is_md_op(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
           (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/execute_stage_if.sv
// ---------------------------------------------------------------------------
// execute_stage_if : ID/EX inputs and EX/MEM outputs of the execute stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface execute_stage_if
  import mips_pkg::*;
#(
  parameter int WIDTH      = WORD_W,
  parameter int REG_ADDR_W = 5
);

  logic                  valid_in;
  logic [1:0]            wb_EX;
  logic [2:0]            m_EX;
  alu_op_t               alu_op;
  logic                  alu_src;
  logic                  reg_dst;
  logic [WIDTH-1:0]      read_data1;
  logic [WIDTH-1:0]      read_data2;
  logic [WIDTH-1:0]      imm_ext;
  logic [4:0]            shamt;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;

  logic [1:0]            wb_MEM;
  logic [2:0]            m;
  logic                  zero;
  logic [WIDTH-1:0]      address_MEM;
  logic [WIDTH-1:0]      write_data_mem;
  logic [REG_ADDR_W-1:0] write_register_ex;
  logic                  stall;
  logic                  md_busy;

  modport master (
    output valid_in, wb_EX, m_EX, alu_op, alu_src, reg_dst,
           read_data1, read_data2, imm_ext, shamt, rt, rd,
    input  wb_MEM, m, zero, address_MEM, write_data_mem, write_register_ex,
           stall, md_busy
  );

  modport slave (
    input  valid_in, wb_EX, m_EX, alu_op, alu_src, reg_dst,
           read_data1, read_data2, imm_ext, shamt, rt, rd,
    output wb_MEM, m, zero, address_MEM, write_data_mem, write_register_ex,
           stall, md_busy
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit : iterative shift-add multiply / restoring divide owning HI/LO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  alu_op_t          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mt_hi,
  input  logic             i_mt_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy
);

  localparam int c_cnt_w = $clog2(WIDTH);

  logic               r_busy, r_is_div, r_neg_res, r_neg_rem, r_div0;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_acc, r_q, r_d, r_hi, r_lo;

  logic               w_div, w_sgn, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum, w_shl, w_diff;
  logic [WIDTH-1:0]   w_acc_nx, w_q_nx;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_div   = (i_op == OP_DIV) || (i_op == OP_DIVU);
  assign w_sgn   = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_a_neg = w_sgn & i_a[WIDTH-1];
  assign w_b_neg = w_sgn & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // r_acc holds the product high half or the partial remainder; r_q holds the
  // multiplier (shifted out) or the dividend/quotient (shifted through).
  always_comb begin
    w_sum    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_d} : '0);
    w_shl    = {r_acc, r_q[WIDTH-1]};
    w_diff   = w_shl - {1'b0, r_d};
    w_acc_nx = w_sum[WIDTH:1];
    w_q_nx   = {w_sum[0], r_q[WIDTH-1:1]};
    if (r_is_div) begin
      if (!w_diff[WIDTH]) begin
        w_acc_nx = w_diff[WIDTH-1:0];
        w_q_nx   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nx = w_shl[WIDTH-1:0];
        w_q_nx   = {r_q[WIDTH-2:0], 1'b0};
      end
    end
    w_prod     = {w_acc_nx, w_q_nx};
    w_prod_fix = r_neg_res ? -w_prod : w_prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_cnt     <= c_cnt_w'(WIDTH - 1);
      r_is_div  <= w_div;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_div0    <= (i_b == '0);
      r_acc     <= '0;
      r_q       <= w_a_mag;
      r_d       <= w_b_mag;
    end else if (r_busy) begin
      r_acc <= w_acc_nx;
      r_q   <= w_q_nx;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
        if (r_is_div) begin
          // Divide by zero keeps the raw all-ones quotient; the remainder
          // sign fix then restores the original dividend into HI.
          r_lo <= (r_neg_res & ~r_div0) ? -w_q_nx : w_q_nx;
          r_hi <= r_neg_rem ? -w_acc_nx : w_acc_nx;
        end else begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end
      end else begin
        r_cnt <= r_cnt - c_cnt_w'(1);
      end
    end else begin
      if (i_mt_hi) r_hi <= i_a;
      if (i_mt_lo) r_lo <= i_a;
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage : MIPS EX stage - ALU, operand/destination mux, EX/MEM register
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module execute_stage
  import mips_pkg::*;
#(
  parameter int WIDTH      = WORD_W,
  parameter int REG_ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  execute_stage_if.slave ex
);

  logic [WIDTH-1:0]      w_b, w_alu, w_hi, w_lo;
  logic                  w_stall, w_issue, w_md_start, w_mt_hi, w_mt_lo, w_md_busy;

  logic [1:0]            r_wb;
  logic [2:0]            r_m;
  logic                  r_zero;
  logic [WIDTH-1:0]      r_addr, r_wdata;
  logic [REG_ADDR_W-1:0] r_wreg;

  assign w_b        = ex.alu_src ? ex.imm_ext : ex.read_data2;
  assign w_stall    = ex.valid_in & w_md_busy & is_hilo_op(ex.alu_op);
  assign w_issue    = ex.valid_in & ~w_stall;
  assign w_md_start = w_issue & is_md_op(ex.alu_op);
  assign w_mt_hi    = w_issue & (ex.alu_op == OP_MTHI);
  assign w_mt_lo    = w_issue & (ex.alu_op == OP_MTLO);

  always_comb begin
    w_alu = '0;
    case (ex.alu_op)
      OP_ADD:  w_alu = ex.read_data1 + w_b;
      OP_SUB:  w_alu = ex.read_data1 - w_b;
      OP_AND:  w_alu = ex.read_data1 & w_b;
      OP_OR:   w_alu = ex.read_data1 | w_b;
      OP_XOR:  w_alu = ex.read_data1 ^ w_b;
      OP_NOR:  w_alu = ~(ex.read_data1 | w_b);
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(ex.read_data1) < $signed(w_b))};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (ex.read_data1 < w_b)};
      OP_LUI:  w_alu = w_b << 16;
      OP_SLL:  w_alu = ex.read_data2 << ex.shamt;
      OP_SRL:  w_alu = ex.read_data2 >> ex.shamt;
      OP_SRA:  w_alu = $unsigned($signed(ex.read_data2) >>> ex.shamt);
      OP_SLLV: w_alu = ex.read_data2 << ex.read_data1[4:0];
      OP_SRLV: w_alu = ex.read_data2 >> ex.read_data1[4:0];
      OP_SRAV: w_alu = $unsigned($signed(ex.read_data2) >>> ex.read_data1[4:0]);
      OP_MFHI: w_alu = w_hi;
      OP_MFLO: w_alu = w_lo;
      default: w_alu = '0;
    endcase
  end

  muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_md_start),
    .i_op    (ex.alu_op),
    .i_a     (ex.read_data1),
    .i_b     (ex.read_data2),
    .i_mt_hi (w_mt_hi),
    .i_mt_lo (w_mt_lo),
    .o_hi    (w_hi),
    .o_lo    (w_lo),
    .o_busy  (w_md_busy)
  );

  // Stalled or empty slots register a bubble with data zeroed as well
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb    <= '0;
      r_m     <= '0;
      r_zero  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wreg  <= '0;
    end else if (w_issue) begin
      r_wb    <= ex.wb_EX;
      r_m     <= ex.m_EX;
      r_zero  <= (w_alu == '0);
      r_addr  <= w_alu;
      r_wdata <= ex.read_data2;
      r_wreg  <= ex.reg_dst ? ex.rd : ex.rt;
    end else begin
      r_wb    <= '0;
      r_m     <= '0;
      r_zero  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wreg  <= '0;
    end
  end

  assign ex.wb_MEM            = r_wb;
  assign ex.m                 = r_m;
  assign ex.zero              = r_zero;
  assign ex.address_MEM       = r_addr;
  assign ex.write_data_mem    = r_wdata;
  assign ex.write_register_ex = r_wreg;
  assign ex.stall             = w_stall;
  assign ex.md_busy           = w_md_busy;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage : directed self-checking bench for execute_stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_execute_stage;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  execute_stage_if #(.WIDTH(32), .REG_ADDR_W(5)) bus ();

  execute_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.valid_in   = 1'b1;
    bus.wb_EX      = 2'b00;
    bus.m_EX       = 3'b000;
    bus.alu_op     = op;
    bus.alu_src    = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.read_data1 = a;
    bus.read_data2 = b;
    bus.imm_ext    = '0;
    bus.shamt      = '0;
    bus.rt         = '0;
    bus.rd         = '0;
  endtask

  // Issue MFHI/MFLO, ride out any stall, return the registered value
  task automatic read_hilo(input alu_op_t op, input bit chk_bubble,
                           output logic [31:0] val, output int stalls);
    set_op(op, 32'd0, 32'd0);
    bus.wb_EX = 2'b10;
    bus.rt    = 5'd2;
    stalls    = 0;
    #1;
    while (bus.stall && stalls < 100) begin
      step();
      stalls++;
      if (chk_bubble) begin
        check_eq("stall_bubble_wb", {30'd0, bus.wb_MEM}, 32'd0);
        check_eq("stall_bubble_m", {29'd0, bus.m}, 32'd0);
      end
    end
    step();
    val = bus.address_MEM;
  endtask

  logic [31:0] v_hi, v_lo;
  int          v_st;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_op(OP_ADD, 32'd0, 32'd0);
    bus.valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_addr", bus.address_MEM, 32'd0);
    check_eq("rst_wb", {30'd0, bus.wb_MEM}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.md_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD wraps to zero
    set_op(OP_ADD, 32'd7, 32'd0);
    bus.alu_src = 1'b1; bus.imm_ext = 32'hFFFF_FFF9; bus.wb_EX = 2'b10; bus.rt = 5'd5;
    step();
    check_eq("add_addr", bus.address_MEM, 32'd0);
    check_eq("add_zero", {31'd0, bus.zero}, 32'd1);
    check_eq("add_wreg", {27'd0, bus.write_register_ex}, 32'd5);
    check_eq("add_wb", {30'd0, bus.wb_MEM}, 32'd2);

    // Store address and data
    set_op(OP_ADD, 32'd4, 32'hDEAD_BEEF);
    bus.alu_src = 1'b1; bus.imm_ext = 32'd8; bus.m_EX = 3'b001;
    step();
    check_eq("sw_addr", bus.address_MEM, 32'd12);
    check_eq("sw_data", bus.write_data_mem, 32'hDEAD_BEEF);
    check_eq("sw_m", {29'd0, bus.m}, 32'd1);
    check_eq("sw_zero", {31'd0, bus.zero}, 32'd0);

    set_op(OP_SRA, 32'd0, 32'h8000_0000); bus.shamt = 5'd4;
    step(); check_eq("sra", bus.address_MEM, 32'hF800_0000);
    set_op(OP_SLTU, 32'd1, 32'hFFFF_FFFF);
    step(); check_eq("sltu", bus.address_MEM, 32'd1);
    set_op(OP_SLT, 32'd1, 32'hFFFF_FFFF);
    step(); check_eq("slt", bus.address_MEM, 32'd0);
    check_eq("slt_zero", {31'd0, bus.zero}, 32'd1);
    set_op(OP_SUB, 32'd5, 32'd7);
    step(); check_eq("sub", bus.address_MEM, 32'hFFFF_FFFE);
    set_op(OP_NOR, 32'h0F0F_0000, 32'h0000_00F0);
    step(); check_eq("nor", bus.address_MEM, 32'hF0F0_FF0F);
    set_op(OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0);
    step(); check_eq("xor", bus.address_MEM, 32'hF0F0_F0F0);
    set_op(OP_LUI, 32'd0, 32'd0); bus.alu_src = 1'b1; bus.imm_ext = 32'h0000_1234;
    step(); check_eq("lui", bus.address_MEM, 32'h1234_0000);
    set_op(OP_SLLV, 32'hFFFF_FFE4, 32'd3);
    step(); check_eq("sllv", bus.address_MEM, 32'h0000_0030);
    set_op(OP_SRLV, 32'h0000_0024, 32'h8000_0000);
    step(); check_eq("srlv", bus.address_MEM, 32'h0800_0000);
    set_op(OP_OR, 32'h10, 32'h01); bus.reg_dst = 1'b1; bus.rd = 5'd9; bus.rt = 5'd4;
    step(); check_eq("or", bus.address_MEM, 32'h11);
    check_eq("rd_sel", {27'd0, bus.write_register_ex}, 32'd9);
    set_op(alu_op_t'(5'd31), 32'd5, 32'd5); bus.wb_EX = 2'b11;
    step(); check_eq("bad_op", bus.address_MEM, 32'd0);
    check_eq("bad_op_zero", {31'd0, bus.zero}, 32'd1);
    set_op(OP_ADD, 32'd5, 32'd5); bus.valid_in = 1'b0; bus.wb_EX = 2'b11; bus.m_EX = 3'b010; bus.rt = 5'd7;
    step(); check_eq("bubble_wb", {30'd0, bus.wb_MEM}, 32'd0);
    check_eq("bubble_m", {29'd0, bus.m}, 32'd0);
    check_eq("bubble_wreg", {27'd0, bus.write_register_ex}, 32'd0);

    // MULT -3 x 5 followed by MFLO, MFHI
    set_op(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    #1; check_eq("mult_nostall", {31'd0, bus.stall}, 32'd0);
    step(); check_eq("mult_busy", {31'd0, bus.md_busy}, 32'd1);
    read_hilo(OP_MFLO, 1'b1, v_lo, v_st);
    check_eq("mult_stalls", v_st, 32'd32);
    check_eq("mult_lo", v_lo, 32'hFFFF_FFF1);
    check_eq("mflo_wb", {30'd0, bus.wb_MEM}, 32'd2);
    check_eq("mult_idle", {31'd0, bus.md_busy}, 32'd0);
    read_hilo(OP_MFHI, 1'b0, v_hi, v_st);
    check_eq("mfhi_nostall", v_st, 32'd0);
    check_eq("mult_hi", v_hi, 32'hFFFF_FFFF);

    set_op(OP_MTHI, 32'h0000_1234, 32'd0); step();
    set_op(OP_MTLO, 32'h0000_5678, 32'd0); step();
    read_hilo(OP_MFHI, 1'b0, v_hi, v_st); check_eq("mthi", v_hi, 32'h0000_1234);
    read_hilo(OP_MFLO, 1'b0, v_lo, v_st); check_eq("mtlo", v_lo, 32'h0000_5678);

    set_op(OP_DIV, 32'hFFFF_FFF9, 32'd2); step();
    read_hilo(OP_MFLO, 1'b0, v_lo, v_st); check_eq("div_lo", v_lo, 32'hFFFF_FFFD);
    read_hilo(OP_MFHI, 1'b0, v_hi, v_st); check_eq("div_hi", v_hi, 32'hFFFF_FFFF);
    set_op(OP_DIVU, 32'd5, 32'd0); step();
    read_hilo(OP_MFLO, 1'b0, v_lo, v_st); check_eq("div0_lo", v_lo, 32'hFFFF_FFFF);
    read_hilo(OP_MFHI, 1'b0, v_hi, v_st); check_eq("div0_hi", v_hi, 32'd5);
    set_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF); step();
    read_hilo(OP_MFLO, 1'b0, v_lo, v_st); check_eq("divmin_lo", v_lo, 32'h8000_0000);
    read_hilo(OP_MFHI, 1'b0, v_hi, v_st); check_eq("divmin_hi", v_hi, 32'd0);
    set_op(OP_DIVU, 32'd100, 32'd7); step();
    read_hilo(OP_MFLO, 1'b0, v_lo, v_st); check_eq("divu_lo", v_lo, 32'd14);
    read_hilo(OP_MFHI, 1'b0, v_hi, v_st); check_eq("divu_hi", v_hi, 32'd2);
    set_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step();
    read_hilo(OP_MFHI, 1'b0, v_hi, v_st); check_eq("multu_hi", v_hi, 32'hFFFF_FFFE);
    read_hilo(OP_MFLO, 1'b0, v_lo, v_st); check_eq("multu_lo", v_lo, 32'h0000_0001);

    // Reset at iteration 10 of a DIVU; independent ALU ops flow meanwhile
    set_op(OP_DIVU, 32'd100, 32'd7); step();
    for (int i = 1; i <= 10; i++) begin
      set_op(OP_ADD, i, 32'd0);
      bus.alu_src = 1'b1; bus.imm_ext = 32'd1; bus.wb_EX = 2'b10; bus.rt = 5'd3;
      step();
    end
    check_eq("pre_rst_busy", {31'd0, bus.md_busy}, 32'd1);
    check_eq("pre_rst_addr", bus.address_MEM, 32'd11);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_addr", bus.address_MEM, 32'd0);
    check_eq("arst_wb", {30'd0, bus.wb_MEM}, 32'd0);
    check_eq("arst_wreg", {27'd0, bus.write_register_ex}, 32'd0);
    check_eq("arst_busy", {31'd0, bus.md_busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    read_hilo(OP_MFHI, 1'b0, v_hi, v_st);
    check_eq("post_rst_stall", v_st, 32'd0);
    check_eq("post_rst_hi", v_hi, 32'd0);
    check_eq("post_rst_wb", {30'd0, bus.wb_MEM}, 32'd2);
    read_hilo(OP_MFLO, 1'b0, v_lo, v_st);
    check_eq("post_rst_lo", v_lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
